// File: rtl/vga_timing_pkg.sv
// Shared timing description for the VGA raster generator: mode record, the
// standard 640x480@60 mode and helpers for axis totals and counter widths.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  function automatic int unsigned axis_total(int unsigned active, int unsigned fp,
                                             int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Bits needed to hold total-1
  function automatic int unsigned cnt_width(int unsigned total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wrapping position counter plus combinational sync/active
// decode of the position it currently holds.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter logic        POL    = 1'b0,
  parameter int unsigned W      = 10
) (
  input  logic         pclk,
  input  logic         reset_n,
  input  logic         step,
  output logic         wrap,
  output logic [W-1:0] pos,
  output logic         sync,
  output logic         active
);

  localparam int unsigned TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned SYNC_BEG = ACTIVE + FP;
  localparam int unsigned SYNC_END = SYNC_BEG + SYNC;

  if ((ACTIVE == 0) || (FP == 0) || (SYNC == 0) || (BP == 0)) begin : g_bad_timing
    $error("vga_axis_counter: every timing term must be at least 1");
  end
  if (W < cnt_width(TOTAL)) begin : g_bad_width
    $error("vga_axis_counter: W too narrow for axis total");
  end

  logic [W-1:0] pos_q;
  logic [W-1:0] pos_d;
  logic         last;

  assign last = (pos_q == W'(TOTAL - 1));

  always_comb begin
    pos_d = pos_q;
    if (step) begin
      pos_d = last ? '0 : pos_q + W'(1);
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) pos_q <= '0;
    else          pos_q <= pos_d;
  end

  assign wrap   = step & last;
  assign pos    = pos_q;
  assign sync   = ((pos_q >= W'(SYNC_BEG)) && (pos_q < W'(SYNC_END))) ? POL : ~POL;
  assign active = (pos_q < W'(ACTIVE));

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. The axis counters hold the next
// position; every output is a register loaded with its decode on enabled edges.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640X480_60.h_active,
  parameter int unsigned H_FP     = VGA_640X480_60.h_fp,
  parameter int unsigned H_SYNC   = VGA_640X480_60.h_sync,
  parameter int unsigned H_BP     = VGA_640X480_60.h_bp,
  parameter int unsigned V_ACTIVE = VGA_640X480_60.v_active,
  parameter int unsigned V_FP     = VGA_640X480_60.v_fp,
  parameter int unsigned V_SYNC   = VGA_640X480_60.v_sync,
  parameter int unsigned V_BP     = VGA_640X480_60.v_bp,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             pclk,
  input  logic             reset_n,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             valid,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             line_start,
  output logic             frame_start,
  output logic             vblank_start
);

  logic             h_wrap;
  logic [CNT_W-1:0] h_pos;
  logic             h_sync;
  logic             h_act;
  logic             unused_v_wrap;
  logic [CNT_W-1:0] v_pos;
  logic             v_sync;
  logic             v_act;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .W(CNT_W)
  ) u_h_axis (
    .pclk   (pclk),
    .reset_n(reset_n),
    .step   (pix_en),
    .wrap   (h_wrap),
    .pos    (h_pos),
    .sync   (h_sync),
    .active (h_act)
  );

  // Vertical axis advances once per completed line
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .W(CNT_W)
  ) u_v_axis (
    .pclk   (pclk),
    .reset_n(reset_n),
    .step   (h_wrap),
    .wrap   (unused_v_wrap),
    .pos    (v_pos),
    .sync   (v_sync),
    .active (v_act)
  );

  logic             hsync_q,        hsync_d;
  logic             vsync_q,        vsync_d;
  logic             valid_q,        valid_d;
  logic [CNT_W-1:0] h_cnt_q,        h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q,        v_cnt_d;
  logic             line_start_q,   line_start_d;
  logic             frame_start_q,  frame_start_d;
  logic             vblank_start_q, vblank_start_d;

  // Outputs hold between enabled edges so strobes stay up until pix_en returns
  always_comb begin
    hsync_d        = hsync_q;
    vsync_d        = vsync_q;
    valid_d        = valid_q;
    h_cnt_d        = h_cnt_q;
    v_cnt_d        = v_cnt_q;
    line_start_d   = line_start_q;
    frame_start_d  = frame_start_q;
    vblank_start_d = vblank_start_q;
    if (pix_en) begin
      hsync_d        = h_sync;
      vsync_d        = v_sync;
      valid_d        = h_act & v_act;
      h_cnt_d        = h_act ? h_pos : '0;
      v_cnt_d        = v_act ? v_pos : '0;
      line_start_d   = (h_pos == '0);
      frame_start_d  = (h_pos == '0) && (v_pos == '0);
      vblank_start_d = (h_pos == '0) && (v_pos == CNT_W'(V_ACTIVE));
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q        <= ~H_POL;
      vsync_q        <= ~V_POL;
      valid_q        <= 1'b0;
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      valid_q        <= valid_d;
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end

  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign valid        = valid_q;
  assign h_cnt        = h_cnt_q;
  assign v_cnt        = v_cnt_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two small modes (normal and inverted
// polarity) driven by a shared pix_en, checked against a raster-position model.
module tb_vga_timing_gen;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic         hs;
    logic         vs;
    logic         vld;
    logic [W-1:0] hc;
    logic [W-1:0] vc;
    logic         ls;
    logic         fs;
    logic         vb;
  } obs_t;

  typedef struct {
    int ha, hfp, hsw, hbp;
    int va, vfp, vsw, vbp;
    bit hp, vp;
  } mode_t;

  logic pclk, reset_n, pix_en;

  logic         hs0, vs0, vld0, ls0, fs0, vb0;
  logic [W-1:0] hc0, vc0;
  logic         hs1, vs1, vld1, ls1, fs1, vb1;
  logic [W-1:0] hc1, vc1;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b0), .CNT_W(W)
  ) u_dut0 (
    .pclk(pclk), .reset_n(reset_n), .pix_en(pix_en),
    .hsync(hs0), .vsync(vs0), .valid(vld0), .h_cnt(hc0), .v_cnt(vc0),
    .line_start(ls0), .frame_start(fs0), .vblank_start(vb0)
  );

  vga_timing_gen #(
    .H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(3), .V_FP(2), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(W)
  ) u_dut1 (
    .pclk(pclk), .reset_n(reset_n), .pix_en(pix_en),
    .hsync(hs1), .vsync(vs1), .valid(vld1), .h_cnt(hc1), .v_cnt(vc1),
    .line_start(ls1), .frame_start(fs1), .vblank_start(vb1)
  );

  obs_t obs0, obs1;
  assign obs0 = {hs0, vs0, vld0, hc0, vc0, ls0, fs0, vb0};
  assign obs1 = {hs1, vs1, vld1, hc1, vc1, ls1, fs1, vb1};

  mode_t m0, m1;
  int h0, v0, h1, v1;
  obs_t q0[$];
  obs_t q1[$];
  obs_t cur0, cur1;
  bit   mon_en;
  bit   fs_seen;
  int   en_cnt;
  int   frames0;
  int   errors;
  int   checks;
  string phase;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic obs_t ref_out(mode_t m, int h, int v);
    obs_t o;
    int hsb = m.ha + m.hfp;
    int vsb = m.va + m.vfp;
    o.hs  = (h >= hsb && h < hsb + m.hsw) ? m.hp : ~m.hp;
    o.vs  = (v >= vsb && v < vsb + m.vsw) ? m.vp : ~m.vp;
    o.vld = (h < m.ha) && (v < m.va);
    o.hc  = (h < m.ha) ? W'(h) : '0;
    o.vc  = (v < m.va) ? W'(v) : '0;
    o.ls  = (h == 0);
    o.fs  = (h == 0) && (v == 0);
    o.vb  = (h == 0) && (v == m.va);
    return o;
  endfunction

  function automatic obs_t reset_out(mode_t m);
    obs_t o = '0;
    o.hs = ~m.hp;
    o.vs = ~m.vp;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("hs=%0b vs=%0b valid=%0b h_cnt=%0d v_cnt=%0d ls=%0b fs=%0b vb=%0b",
                     o.hs, o.vs, o.vld, o.hc, o.vc, o.ls, o.fs, o.vb);
  endfunction

  function automatic void chk_obs(string name, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%s] actual: %s | required: %s", name, phase, fmt(act), fmt(exp));
    end
  endfunction

  function automatic void chk_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s [%s] actual=%0d required=%0d", name, phase, act, exp);
    end
  endfunction

  task automatic adv(input mode_t m, inout int h, inout int v);
    h++;
    if (h == m.ha + m.hfp + m.hsw + m.hbp) begin
      h = 0;
      v++;
      if (v == m.va + m.vfp + m.vsw + m.vbp) v = 0;
    end
  endtask

  // Stimulus: choose pix_en for the next edge and queue the expected response
  task automatic drive(input bit en);
    @(negedge pclk);
    pix_en = en;
    if (en) begin
      q0.push_back(ref_out(m0, h0, v0));
      q1.push_back(ref_out(m1, h1, v1));
      adv(m0, h0, v0);
      adv(m1, h1, v1);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    h0 = 0; v0 = 0; h1 = 0; v1 = 0;
    cur0 = reset_out(m0);
    cur1 = reset_out(m1);
    fs_seen = 1'b0;
    en_cnt = 0;
  endtask

  // Asynchronous reset between edges, then release with pix_en low
  task automatic mid_reset();
    @(negedge pclk);
    #2;
    mon_en  = 1'b0;
    pix_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_obs("async_reset_dut0", obs0, reset_out(m0));
    chk_obs("async_reset_dut1", obs1, reset_out(m1));
    model_reset();
    @(posedge pclk);
    #1;
    chk_obs("reset_hold_dut0", obs0, reset_out(m0));
    @(negedge pclk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
  endtask

  // Monitor: pop a new expectation on each enabled edge, otherwise require a hold
  initial begin
    bit en_s;
    forever begin
      @(posedge pclk);
      en_s = pix_en;
      #1;
      if (mon_en) begin
        if (en_s) begin
          if (q0.size() == 0 || q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL queue_underflow [%s] actual=empty required=entry", phase);
          end else begin
            cur0 = q0.pop_front();
            cur1 = q1.pop_front();
          end
          en_cnt++;
          if (obs0.fs) begin
            if (fs_seen) chk_int("frame_period_dut0", en_cnt, 120);
            fs_seen = 1'b1;
            en_cnt  = 0;
            frames0++;
          end
        end
        chk_obs("dut0", obs0, cur0);
        chk_obs("dut1", obs1, cur1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors  = 0;
    checks  = 0;
    frames0 = 0;
    mon_en  = 1'b0;
    phase   = "reset";
    m0 = '{ha: 8, hfp: 2, hsw: 3, hbp: 2, va: 4, vfp: 1, vsw: 1, vbp: 2, hp: 1'b0, vp: 1'b0};
    m1 = '{ha: 5, hfp: 1, hsw: 2, hbp: 3, va: 3, vfp: 2, vsw: 1, vbp: 1, hp: 1'b1, vp: 1'b1};
    reset_n = 1'b0;
    pix_en  = 1'b0;
    model_reset();
    repeat (3) @(negedge pclk);
    chk_obs("por_dut0", obs0, reset_out(m0));
    chk_obs("por_dut1", obs1, reset_out(m1));
    reset_n = 1'b1;
    mon_en  = 1'b1;

    phase = "idle_after_release";
    repeat (4) drive(1'b0);

    phase = "continuous";
    repeat (300) drive(1'b1);

    phase = "pattern_1001";
    for (int i = 0; i < 400; i++) drive((i % 4 == 0) || (i % 4 == 3));

    phase = "reset_mid_frame";
    repeat (57) drive(1'b1);
    mid_reset();
    repeat (2) drive(1'b0);
    repeat (130) drive(1'b1);

    phase = "random_enable";
    repeat (1500) drive($urandom_range(0, 3) != 0);

    phase = "second_reset";
    mid_reset();
    repeat (250) drive(1'b1);

    phase = "drain";
    repeat (3) drive(1'b0);
    chk_int("queue_drained_dut0", q0.size(), 0);
    chk_int("queue_drained_dut1", q1.size(), 0);
    checks++;
    if (frames0 < 10) begin
      errors++;
      $display("FAIL frame_count_dut0 actual=%0d required>=10", frames0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
